// File: rtl/vxe_pipe_pkg.sv
// Shared definitions for the vxe_pipe family: log2 helper, default sizes and
// the pointer/credit width used by the receive buffer.
package vxe_pipe_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 8;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // One extra bit distinguishes full from empty and lets credits reach DEPTH.
    function automatic int ptr_w(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/vxe_pipe_sink_mem.sv
// Receive-buffer storage: DEPTH x DATA_WIDTH register array,
// synchronous write, asynchronous read, no reset on the contents.
module vxe_pipe_sink_mem
    import vxe_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [clog2(DEPTH)-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [clog2(DEPTH)-1:0]  raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/vxe_pipe_sink.sv
// Credit-managed receive buffer turning the fixed-latency vxe_pipe output into
// a valid/ready stream. Optional sticky error flag: VXE_PIPE_SINK_ERR_CHECK_EN.
module vxe_pipe_sink
    import vxe_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  issue,
    output logic                  crd_ok,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_rdy,
    output logic                  err
);

    localparam int AW = clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] crd;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;

    // Saturating credit update; a simultaneous issue and pop cancel out.
    function automatic logic [PW-1:0] crd_next(input logic [PW-1:0] c,
                                               input logic iss,
                                               input logic pp);
        if (iss && !pp)
            return (c == '0) ? c : c - PW'(1);
        else if (pp && !iss)
            return c + PW'(1);
        return c;
    endfunction

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_valid = !empty;
    assign pop       = out_valid && out_rdy;
    // The slot freed by a pop is reusable in the same cycle, even when full.
    assign push      = in_valid && (!full || pop);
    assign crd_ok    = (crd != '0);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            crd    <= PW'(DEPTH);
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            crd <= crd_next(crd, issue, pop);
        end
    end

`ifdef VXE_PIPE_SINK_ERR_CHECK_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            err <= 1'b0;
        else if ((in_valid && full && !pop) || (issue && crd == '0))
            err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

    vxe_pipe_sink_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (out_data)
    );

endmodule

// File: tb/tb_vxe_pipe_sink.sv
// Bench for vxe_pipe_sink: a 5-stage pipe model feeds the DUT, and a
// queue/credit reference model predicts every output after each clock edge.
module tb_vxe_pipe_sink;

    localparam int DEPTH = 8;
    localparam int NS    = 5;
`ifdef VXE_PIPE_SINK_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        nrst;
    logic        issue;
    logic        crd_ok;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_rdy;
    logic        err;

    int checks;
    int errors;

    // Reference model state
    logic [31:0] q[$];
    int          mcrd;
    bit          merr;
    bit          pv [NS];
    logic [31:0] pd [NS];

    vxe_pipe_sink #(
        .DATA_WIDTH (32),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .issue     (issue),
        .crd_ok    (crd_ok),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_rdy   (out_rdy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [3:0] occ;
        occ = dut.wr_ptr - dut.rd_ptr;
        chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
        if (q.size() != 0)
            chk("out_data", {32'd0, out_data}, {32'd0, q[0]});
        chk("crd_ok", {63'd0, crd_ok}, {63'd0, mcrd != 0});
        chk("crd", {60'd0, dut.crd}, 64'(mcrd));
        chk("occupancy", {60'd0, occ}, 64'(q.size()));
        chk("err", {63'd0, err}, {63'd0, merr});
    endtask

    // One clock: present inputs, advance the model, then compare after the edge.
    // dv/dd drive in_valid/in_data directly instead of taking the pipe output.
    task automatic step(input bit iss, input logic [31:0] idat, input bit rdy,
                        input bit dv, input logic [31:0] dd);
        bit          iv;
        logic [31:0] ivd;
        bit          pop;
        bit          push;
        iv  = dv ? 1'b1 : pv[NS-1];
        ivd = dv ? dd : pd[NS-1];
        issue    = iss;
        out_rdy  = rdy;
        in_valid = iv;
        in_data  = ivd;
        pop  = (q.size() != 0) && rdy;
        push = iv && ((q.size() < DEPTH) || pop);
        if (ERR_EN && ((iv && q.size() == DEPTH && !pop) || (iss && mcrd == 0)))
            merr = 1'b1;
        if (iss && !pop)
            mcrd = (mcrd == 0) ? 0 : mcrd - 1;
        else if (pop && !iss)
            mcrd = mcrd + 1;
        if (pop)
            void'(q.pop_front());
        if (push)
            q.push_back(ivd);
        for (int s = NS - 1; s > 0; s--) begin
            pv[s] = pv[s-1];
            pd[s] = pd[s-1];
        end
        pv[0] = iss;
        pd[0] = idat;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++)
            step(1'b0, 32'd0, rdy, 1'b0, 32'd0);
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        #2;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_crd_ok", {63'd0, crd_ok}, 64'd1);
        chk("rst_err", {63'd0, err}, 64'd0);
        q.delete();
        mcrd = DEPTH;
        merr = 1'b0;
        for (int s = 0; s < NS; s++) begin
            pv[s] = 1'b0;
            pd[s] = '0;
        end
        issue    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        out_rdy  = 1'b0;
        @(posedge clk);
        #1;
        nrst = 1'b1;
        check_all();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        nrst     = 1'b0;
        issue    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        out_rdy  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Fill: 8 issues with the consumer stalled
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 32'hBEEF_0001 + 32'(i), 1'b0, 1'b0, 32'd0);
        chk("fill_crd_ok_low", {63'd0, crd_ok}, 64'd0);
        idle(NS + 2, 1'b0);
        chk("fill_head", {32'd0, out_data}, 64'hBEEF_0001);
        chk("fill_occ", {60'd0, 4'(dut.wr_ptr - dut.rd_ptr)}, 64'd8);

        // Drain in order on consecutive cycles
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_order", {32'd0, out_data}, 64'(32'hBEEF_0001 + 32'(i)));
            step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
            if (i == 0)
                chk("drain_crd_ok_rise", {63'd0, crd_ok}, 64'd1);
        end
        chk("drain_empty", {63'd0, out_valid}, 64'd0);

        // Streaming: issue every cycle, consumer always ready
        for (int i = 0; i < 100; i++) begin
            step(1'b1, $urandom, 1'b1, 1'b0, 32'd0);
            if (i >= NS + 1) begin
                chk("stream_no_gap", {63'd0, out_valid}, 64'd1);
                chk("stream_crd_floor", {63'd0, dut.crd >= 4'(DEPTH - NS - 1)}, 64'd1);
            end
        end
        idle(NS + 3, 1'b1);

        // Full with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0, 32'd0);
        idle(NS + 2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'd0, 1'b1, 1'b1, 32'hCAFE_0000 + 32'(i));
            chk("full_pushpop_occ", {60'd0, 4'(dut.wr_ptr - dut.rd_ptr)}, 64'd8);
        end
        idle(DEPTH + 1, 1'b1);
        do_reset();

        // Randomized legal traffic
        for (int i = 0; i < 300; i++)
            step((mcrd > 0) && ($urandom_range(0, 3) != 0), $urandom,
                 $urandom_range(0, 2) != 0, 1'b0, 32'd0);
        idle(NS + DEPTH + 2, 1'b1);

        // Reset mid-traffic, then DEPTH issues must be accepted
        for (int i = 0; i < 4; i++)
            step(1'b1, $urandom, 1'b0, 1'b0, 32'd0);
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            chk("post_rst_crd_ok", {63'd0, crd_ok}, 64'd1);
            step(1'b1, $urandom, 1'b0, 1'b0, 32'd0);
        end
        idle(NS + 2, 1'b0);
        chk("post_rst_occ", {60'd0, 4'(dut.wr_ptr - dut.rd_ptr)}, 64'd8);
        do_reset();

        // Protocol errors: issue with no credit, then overflow push at full
        for (int i = 0; i < DEPTH + 1; i++)
            step(1'b1, 32'hE000_0000 + 32'(i), 1'b0, 1'b0, 32'd0);
        chk("err_crd_sat", {60'd0, dut.crd}, 64'd0);
        chk("err_flag", {63'd0, err}, {63'd0, ERR_EN});
        idle(NS + 2, 1'b0);
        chk("err_head", {32'd0, out_data}, 64'hE000_0000);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
